// File: rtl/ls_frame_ctrl_pkg.sv
// Shared types and constants for the LED string frame sequencer.
package ls_frame_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SOF  = 2'd1,
    ST_PIX  = 2'd2,
    ST_EOF  = 2'd3
  } state_t;

  localparam int CSR_CTRL   = 0;
  localparam int CSR_DIV    = 1;
  localparam int START_BIT  = 0;
  localparam int BUSY_BIT   = 1;
  localparam int BRIGHT_LSB = 8;
  localparam int BRIGHT_MSB = 12;
  localparam int WORD_BITS  = 32;

  localparam logic [2:0]  PIX_HDR  = 3'b111;
  localparam logic [31:0] SOF_WORD = 32'h0000_0000;
  localparam logic [31:0] EOF_WORD = 32'hFFFF_FFFF;

  // End frame must supply at least half a clock per LED for the data to ripple through.
  function automatic int end_bits(input int n_leds);
    int b;
    b = 8 * ((n_leds + 15) / 16);
    return (b > 32) ? b : 32;
  endfunction

  function automatic logic [31:0] pixel_word(input logic [4:0] bright, input logic [23:0] rgb);
    return {PIX_HDR, bright, rgb[7:0], rgb[15:8], rgb[23:16]};
  endfunction

endpackage

// File: rtl/ls_frame_ctrl_buf.sv
// Per-LED RGB buffer: simple dual-port RAM, bus write port, synchronous serializer read port.
module ls_frame_ctrl_buf #(
  parameter int N_LEDS = 150,
  parameter int IW     = 8
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [IW-1:0] i_waddr,
  input  logic [23:0]   i_wdata,
  input  logic [IW-1:0] i_raddr,
  output logic [23:0]   o_rdata
);

  logic [23:0] r_mem [N_LEDS];
  logic [23:0] r_rdata;

  // No reset so the array maps onto block RAM.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
    r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/ls_frame_ctrl.sv
// Wishbone-controlled APA102 frame sequencer: CSRs, pixel buffer, and serial frame engine.
module ls_frame_ctrl
  import ls_frame_ctrl_pkg::*;
#(
  parameter int N_LEDS      = 150,
  parameter int AW          = 10,
  parameter int DW          = 32,
  parameter int DIV_DEFAULT = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] wb_addr,
  output logic [DW-1:0] wb_rdata,
  input  logic [DW-1:0] wb_wdata,
  input  logic          wb_we,
  input  logic          wb_cyc,
  output logic          wb_ack,
  output logic          led_clk,
  output logic          led_data
);

  localparam int IW       = (N_LEDS > 1) ? $clog2(N_LEDS) : 1;
  localparam int END_BITS = end_bits(N_LEDS);
  localparam int BW       = $clog2(END_BITS);
  localparam logic [BW-1:0] LAST_WORD_BIT = BW'(WORD_BITS - 1);
  localparam logic [BW-1:0] LAST_EOF_BIT  = BW'(END_BITS - 1);
  localparam logic [IW-1:0] LAST_LED      = IW'(N_LEDS - 1);

  state_t        r_state;
  state_t        w_state_nxt;
  logic          r_ack;
  logic [DW-1:0] r_rdata;
  logic [DW-1:0] w_rd_mux;
  logic [4:0]    r_bright;
  logic [7:0]    r_div;
  logic [4:0]    r_bright_snap;
  logic [7:0]    r_div_snap;
  logic [15:0]   r_frame_cnt;
  logic          r_led_clk;
  logic [7:0]    r_phase_cnt;
  logic [BW-1:0] r_bit_cnt;
  logic [IW-1:0] r_led_idx;
  logic [31:0]   r_shift;

  logic          w_acc, w_wr, w_is_buf, w_csr0, w_csr1, w_buf_we, w_start, w_busy;
  logic [AW-2:0] w_off;
  logic          w_phase_end, w_fall, w_last_bit, w_last_led, w_frame_done;
  logic [IW-1:0] w_rd_addr;
  logic [23:0]   w_rd_data;
  logic [31:0]   w_pix_word;
  logic          w_unused;

  assign w_acc    = wb_cyc & ~r_ack;
  assign w_wr     = w_acc & wb_we;
  assign w_is_buf = wb_addr[AW-1];
  assign w_off    = wb_addr[AW-2:0];
  assign w_csr0   = ~w_is_buf & (w_off == (AW-1)'(CSR_CTRL));
  assign w_csr1   = ~w_is_buf & (w_off == (AW-1)'(CSR_DIV));
  assign w_buf_we = w_wr & w_is_buf & ({1'b0, w_off} < AW'(N_LEDS));
  assign w_busy   = (r_state != ST_IDLE);
  assign w_start  = w_wr & w_csr0 & wb_wdata[START_BIT] & ~w_busy;
  assign w_unused = ^wb_wdata[DW-1:24];

  assign w_phase_end  = (r_phase_cnt == r_div_snap);
  assign w_fall       = w_busy & w_phase_end & r_led_clk;
  assign w_last_bit   = (r_state == ST_EOF) ? (r_bit_cnt == LAST_EOF_BIT) : (r_bit_cnt == LAST_WORD_BIT);
  assign w_last_led   = (r_led_idx == LAST_LED);
  assign w_frame_done = w_fall & w_last_bit & (r_state == ST_EOF);
  assign w_pix_word   = pixel_word(r_bright_snap, w_rd_data);

  // Next LED is fetched during the final bit of the current word so it is ready at the boundary.
  assign w_rd_addr = ((r_state == ST_PIX) && (r_bit_cnt == LAST_WORD_BIT) && !w_last_led)
                     ? (r_led_idx + IW'(1)) : r_led_idx;

  ls_frame_ctrl_buf #(.N_LEDS(N_LEDS), .IW(IW)) u_buf (
    .clk     (clk),
    .i_we    (w_buf_we),
    .i_waddr (w_off[IW-1:0]),
    .i_wdata (wb_wdata[23:0]),
    .i_raddr (w_rd_addr),
    .o_rdata (w_rd_data)
  );

  // CSR read multiplexer.
  always_comb begin
    w_rd_mux = '0;
    if (w_csr0) begin
      w_rd_mux[BUSY_BIT]              = w_busy;
      w_rd_mux[BRIGHT_MSB:BRIGHT_LSB] = r_bright;
      w_rd_mux[31:16]                 = r_frame_cnt;
    end else if (w_csr1) begin
      w_rd_mux[7:0] = r_div;
    end else begin
      w_rd_mux = '0;
    end
  end

  // Bus acknowledge, read data and CSR writes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ack    <= 1'b0;
      r_rdata  <= '0;
      r_bright <= 5'h1F;
      r_div    <= 8'(DIV_DEFAULT);
    end else begin
      r_ack   <= w_acc;
      r_rdata <= (w_acc & ~wb_we) ? w_rd_mux : '0;
      if (w_wr & w_csr0) begin
        r_bright <= wb_wdata[BRIGHT_MSB:BRIGHT_LSB];
      end
      if (w_wr & w_csr1) begin
        r_div <= wb_wdata[7:0];
      end
    end
  end

  // Frame state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Frame sequencing: segments advance only on the falling edge ending their last bit.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_start) w_state_nxt = ST_SOF; else w_state_nxt = ST_IDLE;
      ST_SOF:  if (w_fall && w_last_bit) w_state_nxt = ST_PIX; else w_state_nxt = ST_SOF;
      ST_PIX:  if (w_fall && w_last_bit && w_last_led) w_state_nxt = ST_EOF; else w_state_nxt = ST_PIX;
      ST_EOF:  if (w_fall && w_last_bit) w_state_nxt = ST_IDLE; else w_state_nxt = ST_EOF;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Counter is assigned every cycle so a held value survives without an explicit load path.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_frame_cnt <= 16'h0000;
    end else begin
      r_frame_cnt <= r_frame_cnt + {15'h0000, w_frame_done};
    end
  end

  // Serial engine: clock divider, bit/LED counters and shift register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_div_snap    <= 8'h00;
      r_bright_snap <= 5'h00;
      r_led_clk     <= 1'b0;
      r_phase_cnt   <= 8'h00;
      r_bit_cnt     <= '0;
      r_led_idx     <= '0;
      r_shift       <= 32'h0000_0000;
    end else if (w_start) begin
      r_div_snap    <= r_div;
      r_bright_snap <= wb_wdata[BRIGHT_MSB:BRIGHT_LSB];
      r_led_clk     <= 1'b0;
      r_phase_cnt   <= 8'h00;
      r_bit_cnt     <= '0;
      r_led_idx     <= '0;
      r_shift       <= SOF_WORD;
    end else if (w_busy && w_phase_end) begin
      r_phase_cnt <= 8'h00;
      r_led_clk   <= ~r_led_clk;
      if (r_led_clk) begin
        if (!w_last_bit) begin
          r_bit_cnt <= r_bit_cnt + BW'(1);
          r_shift   <= {r_shift[30:0], 1'b1};
        end else begin
          r_bit_cnt <= '0;
          case (r_state)
            ST_SOF: r_shift <= w_pix_word;
            ST_PIX: begin
              if (w_last_led) begin
                r_shift <= EOF_WORD;
              end else begin
                r_led_idx <= r_led_idx + IW'(1);
                r_shift   <= w_pix_word;
              end
            end
            ST_EOF:  r_shift <= SOF_WORD;
            default: r_shift <= SOF_WORD;
          endcase
        end
      end
    end else if (w_busy) begin
      r_phase_cnt <= r_phase_cnt + 8'd1;
    end
  end

  assign wb_ack   = r_ack;
  assign wb_rdata = r_rdata;
  assign led_clk  = r_led_clk;
  assign led_data = r_shift[31];

endmodule
